// File: rtl/s832a_test_pkg.sv
// Shared types and constants for the s832a response compactor slice.
// Holds the FSM state type, core I/O counts, default MISR taps/seed and the MISR step function.
package s832a_test_pkg;

  localparam int S832A_NUM_OUT = 19;
  localparam int S832A_NUM_IN  = 18;

  localparam logic [S832A_NUM_OUT-1:0] S832A_POLY_DEFAULT = 19'h00027;
  localparam logic [S832A_NUM_OUT-1:0] S832A_SEED_DEFAULT = 19'h00000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } misr_state_t;

  // One MISR step: shift left, fold the dropped MSB back through the taps, absorb the response.
  function automatic logic [S832A_NUM_OUT-1:0] misr_next(
    input logic [S832A_NUM_OUT-1:0] sig,
    input logic [S832A_NUM_OUT-1:0] resp,
    input logic [S832A_NUM_OUT-1:0] poly
  );
    return {sig[S832A_NUM_OUT-2:0], 1'b0} ^ (sig[S832A_NUM_OUT-1] ? poly : '0) ^ resp;
  endfunction

endpackage

// File: rtl/s832a_resp_misr_if.sv
// Bus between the test sequencer (master) and the response compactor (slave).
// resp_mask exists only when S832A_MISR_MASK_EN is defined.
interface s832a_resp_misr_if
  import s832a_test_pkg::*;
#(
  parameter int WIDTH = S832A_NUM_OUT,
  parameter int CW    = 16
);
  // Handshake: a beat is accepted on a rising CK edge when in_valid=1 while busy=1 and start=0;
  // there is no backpressure, so the sequencer never waits for a ready.
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] resp;
  logic [WIDTH-1:0] golden;
`ifdef S832A_MISR_MASK_EN
  logic [WIDTH-1:0] resp_mask;
`endif
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] sig;
  logic [CW-1:0]    beat_cnt;
  misr_state_t      dbg_state;

`ifdef S832A_MISR_MASK_EN
  modport master (output start, in_valid, resp, golden, resp_mask,
                  input  busy, done, pass, sig, beat_cnt, dbg_state);
  modport slave  (input  start, in_valid, resp, golden, resp_mask,
                  output busy, done, pass, sig, beat_cnt, dbg_state);
`else
  modport master (output start, in_valid, resp, golden,
                  input  busy, done, pass, sig, beat_cnt, dbg_state);
  modport slave  (input  start, in_valid, resp, golden,
                  output busy, done, pass, sig, beat_cnt, dbg_state);
`endif

endinterface

// File: rtl/s832a_misr_core.sv
// Pure MISR signature register: synchronous load of a seed, or one compaction step when enabled.
module s832a_misr_core
  import s832a_test_pkg::*;
#(
  parameter int               WIDTH = S832A_NUM_OUT,
  parameter logic [WIDTH-1:0] POLY  = S832A_POLY_DEFAULT,
  parameter logic [WIDTH-1:0] SEED  = S832A_SEED_DEFAULT
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      q <= SEED;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= misr_next(q, din, POLY);
    end
  end

endmodule

// File: rtl/s832a_resp_misr.sv
// Response compactor for s832a: folds WINDOW accepted beats into a MISR and checks against golden.
// Optional build macro S832A_MISR_MASK_EN adds resp_mask to exclude unstable outputs.
module s832a_resp_misr
  import s832a_test_pkg::*;
#(
  parameter int               WIDTH  = S832A_NUM_OUT,
  parameter logic [WIDTH-1:0] POLY   = S832A_POLY_DEFAULT,
  parameter logic [WIDTH-1:0] SEED   = S832A_SEED_DEFAULT,
  parameter int               WINDOW = 256,
  parameter int               CW     = 16
) (
  input logic                CK,
  input logic                RST,
  s832a_resp_misr_if.slave   bus
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW - 1);

  misr_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             pass_q;
  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] din;
  logic             accept;
  logic             last_beat;

`ifdef S832A_MISR_MASK_EN
  assign din = bus.resp & ~bus.resp_mask;
`else
  assign din = bus.resp;
`endif

  // start has priority: a beat presented with start is discarded, even the final one.
  assign accept    = (state_q == ST_RUN) && bus.in_valid && !bus.start;
  assign last_beat = accept && (cnt_q == LAST_CNT);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.start)      state_d = ST_RUN;
        else if (last_beat) state_d = ST_DONE;
      end
      ST_DONE: if (bus.start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.dbg_state = state_q;
    unique case (state_q)
      ST_RUN:  bus.busy = 1'b1;
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else if (bus.start) begin
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= cnt_q + 1'b1;
      if (last_beat) pass_q <= (misr_next(sig_q, din, POLY) == bus.golden);
    end
  end

  s832a_misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .CK   (CK),
    .RST  (RST),
    .load (bus.start),
    .en   (accept),
    .seed (SEED),
    .din  (din),
    .q    (sig_q)
  );

  assign bus.sig      = sig_q;
  assign bus.pass     = pass_q;
  assign bus.beat_cnt = cnt_q;

endmodule

// File: tb/tb_s832a_resp_misr.sv
// Scoreboard bench for s832a_resp_misr: two instances (WINDOW=4/SEED=0 and WINDOW=1/SEED=0x40000),
// directed plan cases plus randomized windows checked against a polynomial-arithmetic model.
module tb_s832a_resp_misr;

  localparam logic [18:0] POLY = 19'h00027;

  logic CK;
  logic RST;

  s832a_resp_misr_if #(.WIDTH(19), .CW(16)) ifa ();
  s832a_resp_misr_if #(.WIDTH(19), .CW(16)) ifb ();

  s832a_resp_misr #(.WINDOW(4), .SEED(19'h00000)) u_a (.CK(CK), .RST(RST), .bus(ifa.slave));
  s832a_resp_misr #(.WINDOW(1), .SEED(19'h40000)) u_b (.CK(CK), .RST(RST), .bus(ifb.slave));

  // ---------------- clock / reset ----------------
  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] exp_qa[$];
  logic [19:0] exp_qb[$];

  int          m_state[2];
  logic [18:0] m_sig[2];
  int          m_cnt[2];
  int          m_win[2];
  logic [18:0] m_seed[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signature as a GF(2) polynomial: multiply by x, reduce by x^19+x^5+x^2+x+1, add the response.
  function automatic logic [18:0] fold(input logic [18:0] s, input logic [18:0] r);
    logic [19:0] wide;
    wide = {s, 1'b0};
    if (wide[19]) wide = wide ^ {1'b1, POLY};
    return wide[18:0] ^ r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0;
      m_sig[d]   = m_seed[d];
      m_cnt[d]   = 0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input int d, input logic st, input logic v, input logic [18:0] r,
                     input logic [18:0] g, input logic [18:0] m, input bit match_golden);
    logic [18:0] eff;
    logic [18:0] nxt;
    bit          fin;
`ifdef S832A_MISR_MASK_EN
    eff = r & ~m;
`else
    eff = r;
    if (m !== 19'h0) $display("note: resp_mask has no effect in this build");
`endif
    fin = 0;
    nxt = m_sig[d];
    if (!st && m_state[d] == 1 && v) begin
      nxt = fold(m_sig[d], eff);
      fin = (m_cnt[d] + 1 == m_win[d]);
      if (fin && match_golden) g = nxt;
    end
    if (d == 0) begin
      ifa.start = st; ifa.in_valid = v; ifa.resp = r; ifa.golden = g;
      ifb.start = 1'b0; ifb.in_valid = 1'b0;
`ifdef S832A_MISR_MASK_EN
      ifa.resp_mask = m;
`endif
    end else begin
      ifb.start = st; ifb.in_valid = v; ifb.resp = r; ifb.golden = g;
      ifa.start = 1'b0; ifa.in_valid = 1'b0;
`ifdef S832A_MISR_MASK_EN
      ifb.resp_mask = m;
`endif
    end
    @(posedge CK);
    #1;
    if (st) begin
      m_state[d] = 1; m_sig[d] = m_seed[d]; m_cnt[d] = 0;
    end else if (m_state[d] == 1 && v) begin
      m_sig[d] = nxt;
      m_cnt[d]++;
      if (fin) begin
        if (d == 0) exp_qa.push_back({nxt, nxt == g});
        else        exp_qb.push_back({nxt, nxt == g});
        m_state[d] = 2;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1'b0, 1'b0, 19'h0, 19'h0, 19'h0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  logic [1:0]  done_prev = 2'b00;
  logic [19:0] e;
  always @(negedge CK) begin
    if (RST) begin
      done_prev = 2'b00;
    end else begin
      if (ifa.done && !done_prev[0]) begin
        if (exp_qa.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_qa.pop_front();
          chk("a_window_sig", {13'h0, ifa.sig}, {13'h0, e[19:1]});
          chk("a_window_pass", {31'h0, ifa.pass}, {31'h0, e[0]});
        end
      end
      if (ifb.done && !done_prev[1]) begin
        if (exp_qb.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_qb.pop_front();
          chk("b_window_sig", {13'h0, ifb.sig}, {13'h0, e[19:1]});
          chk("b_window_pass", {31'h0, ifb.pass}, {31'h0, e[0]});
        end
      end
      done_prev = {ifb.done, ifa.done};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    m_win[0] = 4; m_seed[0] = 19'h00000;
    m_win[1] = 1; m_seed[1] = 19'h40000;
    model_reset();
    RST = 1'b1;
    ifa.start = 0; ifa.in_valid = 0; ifa.resp = '0; ifa.golden = '0;
    ifb.start = 0; ifb.in_valid = 0; ifb.resp = '0; ifb.golden = '0;
`ifdef S832A_MISR_MASK_EN
    ifa.resp_mask = '0; ifb.resp_mask = '0;
`endif
    repeat (2) @(posedge CK);
    #1;
    chk("rst_busy", {31'h0, ifa.busy}, 32'd0);
    chk("rst_done", {31'h0, ifa.done}, 32'd0);
    chk("rst_pass", {31'h0, ifa.pass}, 32'd0);
    chk("rst_sig_a", {13'h0, ifa.sig}, 32'h0);
    chk("rst_sig_b", {13'h0, ifb.sig}, 32'h40000);
    chk("rst_cnt", {16'h0, ifa.beat_cnt}, 32'd0);
    @(negedge CK);
    RST = 1'b0;
    @(posedge CK);
    #1;

    // Shift accumulate with gaps, WINDOW=4, SEED=0
    cyc(0, 1'b1, 1'b0, 19'h0, 19'h0, 19'h0, 1'b0);
    chk("start_busy", {31'h0, ifa.busy}, 32'd1);
    cyc(0, 1'b0, 1'b1, 19'h00001, 19'h0, 19'h0, 1'b0);
    cyc(0, 1'b0, 1'b1, 19'h00001, 19'h0, 19'h0, 1'b0);
    chk("acc_sig", {13'h0, ifa.sig}, 32'h3);
    chk("acc_cnt", {16'h0, ifa.beat_cnt}, 32'd2);
    cyc(0, 1'b0, 1'b0, 19'h7ffff, 19'h0, 19'h0, 1'b0);
    chk("gap_sig", {13'h0, ifa.sig}, 32'h3);
    cyc(0, 1'b0, 1'b1, 19'h00001, 19'h0, 19'h0, 1'b0);
    chk("third_not_done", {31'h0, ifa.done}, 32'd0);
    cyc(0, 1'b0, 1'b1, 19'h00001, 19'h0000f, 19'h0, 1'b0);
    chk("fourth_done", {31'h0, ifa.done}, 32'd1);
    chk("fourth_sig", {13'h0, ifa.sig}, 32'hf);
    chk("fourth_cnt", {16'h0, ifa.beat_cnt}, 32'd4);
    cyc(0, 1'b0, 1'b1, 19'h7ffff, 19'h0, 19'h0, 1'b0);
    chk("done_hold_sig", {13'h0, ifa.sig}, 32'hf);
    chk("done_hold_cnt", {16'h0, ifa.beat_cnt}, 32'd4);
    chk("done_hold_pass", {31'h0, ifa.pass}, 32'd1);

    // start coinciding with the 4th beat restarts instead of completing
    cyc(0, 1'b1, 1'b0, 19'h0, 19'h0, 19'h0, 1'b0);
    chk("restart_done_drop", {31'h0, ifa.done}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b1, 19'h12345, 19'h0, 19'h0, 1'b0);
    cyc(0, 1'b1, 1'b1, 19'h12345, 19'h0, 19'h0, 1'b1);
    chk("restart_cnt", {16'h0, ifa.beat_cnt}, 32'd0);
    chk("restart_sig", {13'h0, ifa.sig}, 32'h0);
    chk("restart_no_done", {31'h0, ifa.done}, 32'd0);
    chk("restart_busy", {31'h0, ifa.busy}, 32'd1);

    // Async reset mid-window at beat_cnt=3
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b1, 19'h0abcd, 19'h0, 19'h0, 1'b0);
    chk("pre_rst_cnt", {16'h0, ifa.beat_cnt}, 32'd3);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_busy", {31'h0, ifa.busy}, 32'd0);
    chk("arst_done", {31'h0, ifa.done}, 32'd0);
    chk("arst_pass", {31'h0, ifa.pass}, 32'd0);
    chk("arst_sig", {13'h0, ifa.sig}, 32'h0);
    chk("arst_cnt", {16'h0, ifa.beat_cnt}, 32'd0);
    model_reset();
    @(negedge CK);
    RST = 1'b0;
    @(posedge CK);
    #1;
    idle(1);
    chk("post_rst_idle", {30'h0, ifa.dbg_state}, 32'd0);

    // WINDOW=1, SEED=0x40000: feedback and single-beat pass/fail
    cyc(1, 1'b1, 1'b0, 19'h0, 19'h0, 19'h0, 1'b0);
    cyc(1, 1'b0, 1'b1, 19'h00000, 19'h00027, 19'h0, 1'b0);
    chk("fb_sig", {13'h0, ifb.sig}, 32'h27);
    chk("fb_done", {31'h0, ifb.done}, 32'd1);
    chk("fb_pass", {31'h0, ifb.pass}, 32'd1);
    cyc(1, 1'b1, 1'b0, 19'h0, 19'h0, 19'h0, 1'b0);
    cyc(1, 1'b0, 1'b1, 19'h00001, 19'h00000, 19'h0, 1'b0);
    chk("single_fail_pass", {31'h0, ifb.pass}, 32'd0);
`ifdef S832A_MISR_MASK_EN
    cyc(1, 1'b1, 1'b0, 19'h0, 19'h0, 19'h0, 1'b0);
    cyc(1, 1'b0, 1'b1, 19'h7ffff, 19'h0, 19'h7fffe, 1'b1);
    chk("mask_sig", {13'h0, ifb.sig}, 32'h26);
`endif

    // Randomized windows on both instances
    for (int i = 0; i < 400; i++) begin
      int d;
      d = $urandom_range(0, 1);
      cyc(d, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0), 19'($urandom),
          19'($urandom), ($urandom_range(0, 3) == 0) ? 19'($urandom) : 19'h0,
          bit'($urandom_range(0, 1)));
    end
    idle(3);
    chk("a_queue_drained", exp_qa.size(), 32'd0);
    chk("b_queue_drained", exp_qb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/s832a_resp_misr.md
Name: s832a_resp_misr

Overview:
Downstream response compactor for the s832a sequential core. It consumes the core's 19 primary outputs each capture cycle and folds them into a 19-bit MISR signature over a programmable window. At window end it compares the signature against a golden value and reports pass/fail to the test controller. It sits between the s832a instance and the BIST/test sequencer.

Parameters:
WIDTH, 19, response/signature width; must equal the s832a output count.
POLY, 19'h00027, feedback taps (x^19+x^5+x^2+x+1); bit i set = XOR feedback into bit i.
SEED, 19'h00000, signature value loaded on start.
WINDOW, 256, number of accepted beats per signature; legal range 1..65535.
CW, 16, window counter width.

Ports:
CK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse: begin a new signature window
in_valid  input  1  resp is a valid capture beat this cycle
resp  input  WIDTH  s832a outputs {G327,G325,G322,G315,G312,G310,G302,G300,G298,G296,G292,G290,G288,G55,G53,G49,G47,G45,G43}, MSB first
golden  input  WIDTH  expected signature; sampled at window end
busy  output  1  high in RUN
done  output  1  high in DONE
pass  output  1  valid while done; 1 = signature equals golden
sig  output  WIDTH  current signature register
beat_cnt  output  CW  beats accepted in the current window

Behaviour:
- Reset (async, RST=1): state=IDLE, sig=SEED, beat_cnt=0, busy=0, done=0, pass=0. Deasserted synchronously to CK by the environment.
- States: IDLE, RUN, DONE. Encoding is a 2-bit enum.
- IDLE: start -> RUN next edge; sig<=SEED, beat_cnt<=0. in_valid is ignored.
- RUN, in_valid=1: sig <= {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ resp; beat_cnt<=beat_cnt+1.
- RUN, in_valid=0: hold sig and beat_cnt.
- RUN, in_valid=1 and beat_cnt==WINDOW-1: the final update is applied. pass <= (next sig == golden), with golden sampled that same cycle. Next edge state=DONE.
- DONE: sig, pass and beat_cnt hold; in_valid is ignored. start -> RUN with sig<=SEED, beat_cnt<=0; done and pass drop on the same edge.
- start in RUN: restart. sig<=SEED, beat_cnt<=0, and any in_valid beat that cycle is discarded. start wins over the final beat.
- Latency: sig reflects a beat one cycle after acceptance. done rises one cycle after the final beat.
- beat_cnt never wraps: the window terminates at WINDOW. WINDOW=1 completes on the first beat.
- RST mid-window aborts to IDLE immediately. No partial signature is retained.

Optional Feature:
S832A_MISR_MASK_EN
- Defined: adds input port resp_mask[WIDTH-1:0]. The compacted value is resp & ~resp_mask, so unknown or unstable outputs can be excluded.
- Undefined: no port; resp is compacted unmasked.

Decomposition:
- Package s832a_test_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - S832A_NUM_OUT=19, S832A_NUM_IN=18;
  - default POLY/SEED constants;
  - a function misr_next(sig,resp,poly).
- One sub-module is natural: s832a_misr_core, the pure signature register (CK, RST, load, en, seed, din, q). The FSM and counter stay in the top.

Test Plan:
- Single beat: WINDOW=1, SEED=0, start, then one beat of resp=19'h00001 -> sig=19'h00001, done=1 the following cycle; golden=19'h00001 gives pass=1, golden=0 gives pass=0.
- Shift accumulate: WINDOW=2, SEED=0, two beats of resp=19'h00001 -> sig=19'h00003, beat_cnt=2, done=1.
- Feedback: SEED=19'h40000, WINDOW=1, one beat of resp=0 -> sig=19'h00027.
- Gaps and restart: WINDOW=4, valid beats with in_valid low between them -> sig unchanged in idle cycles, done only after the 4th beat. start asserted with the 4th beat -> back to beat_cnt=0, sig=SEED, no done.
- Async reset: assert RST mid-window (beat_cnt=3) between edges -> busy, done and pass drop to 0 and sig=SEED immediately, without waiting for CK.
- Mask (S832A_MISR_MASK_EN): resp=19'h7FFFF, resp_mask=19'h7FFFE, SEED=0, WINDOW=1 -> sig=19'h00001.
